// File: rtl/spi_pkg.sv
// spi_pkg: shared slave state encoding and default frame width for the SPI link.
package spi_pkg;

    localparam int SPI_TRF_BIT_DEF = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: four-wire SPI serial link between master and slave.
interface spi_slave_if;

    logic cs;
    logic sclk;
    logic mosi;
    logic miso;

    modport slave  (input cs, sclk, mosi, output miso);
    modport master (output cs, sclk, mosi, input miso);

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchroniser with rise/fall detection on the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= {STAGES{INIT}};
            prev <= INIT;
        end else begin
            sr   <= {sr[STAGES-2:0], d};
            prev <= sr[STAGES-1];
        end
    end

    always_comb begin
        q    = sr[STAGES-1];
        rise = q & ~prev;
        fall = ~q & prev;
    end

endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave; samples mosi on sclk fall, drives miso on sclk rise, MSB first.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_TRF_BIT = SPI_TRF_BIT_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_slave_if.slave             spi,
    input  logic [SPI_TRF_BIT-1:0] tx_data,
    input  logic                   tx_load,
    output logic                   tx_empty,
    output logic [SPI_TRF_BIT-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   tx_underrun
);

    localparam int CW = $clog2(SPI_TRF_BIT + 1);

    state_t                 state, next;
    logic                   s_cs, s_sclk, s_mosi, rise, fall, prev_cs;
    logic                   unused_cs_rise, unused_cs_fall, unused_mosi_rise, unused_mosi_fall;
    logic                   start, act_rise, act_fall, last, abort;
    logic [CW-1:0]          bit_cnt;
    logic [SPI_TRF_BIT-1:0] tx_buf, tx_shift, rx_shift;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
        .clk(clk), .rst(rst), .d(spi.cs), .q(s_cs), .rise(unused_cs_rise), .fall(unused_cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(spi.sclk), .q(s_sclk), .rise(rise), .fall(fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(spi.mosi), .q(s_mosi), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    always_comb begin
        start    = (state == IDLE) && prev_cs && !s_cs;
        act_rise = (state == SHIFT) && !s_cs && rise;
        act_fall = (state == SHIFT) && !s_cs && fall;
        last     = act_fall && (bit_cnt == CW'(SPI_TRF_BIT - 1));
        abort    = (state == SHIFT) && s_cs;
        busy     = state != IDLE;
        next     = state;
        next     = start ? SHIFT :
                   abort ? IDLE :
                   last ? HOLD :
                   (state == HOLD && s_cs) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cs     <= 1'b1;
            spi.miso    <= 1'b0;
            tx_buf      <= '0;
            tx_empty    <= 1'b1;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            bit_cnt     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            prev_cs     <= s_cs;
            rx_valid    <= last;
            frame_err   <= abort && (bit_cnt != '0);
            tx_underrun <= start && tx_empty;
            // a load coinciding with frame start stays buffered for the next frame
            if (tx_load) begin
                tx_buf   <= tx_data;
                tx_empty <= 1'b0;
            end else if (start) begin
                tx_empty <= 1'b1;
            end
            if (start) begin
                tx_shift <= tx_empty ? '0 : tx_buf;
                bit_cnt  <= '0;
            end
            if (state != SHIFT) begin
                spi.miso <= 1'b0;
            end else if (act_rise) begin
                spi.miso <= tx_shift[SPI_TRF_BIT-1];
                tx_shift <= tx_shift << 1;
            end
            if (act_fall) begin
                rx_shift <= {rx_shift[SPI_TRF_BIT-2:0], s_mosi};
                bit_cnt  <= bit_cnt + CW'(1);
            end
            if (last) rx_data <= {rx_shift[SPI_TRF_BIT-2:0], s_mosi};
        end
    end

endmodule
